rr_priority_arbiter: RTL

Parametrised registered arbiter that generalises the team's combinational priority encoder. It selects one of WIDTH level-sensitive requesters in either fixed-priority or round-robin mode. The chosen index is presented on a valid/ready grant interface and held stable until downstream accepts it. It sits in front of shared resources (bus masters, shared FIFO write ports) where fairness and a stable grant are required.

---
 rtl/rr_priority_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/rr_priority_arbiter.sv
// Registered arbiter for WIDTH level requesters, fixed-priority (MODE 0) or
// round-robin (MODE 1), presenting a held valid/ready grant.
module rr_priority_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int MODE  = 1,
  localparam int ID_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic [WIDTH-1:0] gnt_onehot
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_id, w_id_nxt;
  logic [WIDTH-1:0] r_onehot, w_onehot_nxt;
  logic [ID_W-1:0]  r_ptr, w_ptr_nxt;
  logic [ID_W-1:0]  w_win;
  logic             w_found;

  // Winner search; round-robin scans upward from the pointer with explicit wrap.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (!w_found && req[i]) begin
          w_win   = ID_W'(i);
          w_found = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < WIDTH; k++) begin : g_scan
        int unsigned idx;
        idx = int'(r_ptr) + k;
        if (idx >= WIDTH) idx = idx - WIDTH;
        if (!w_found && req[idx]) begin
          w_win   = ID_W'(idx);
          w_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_id_nxt     = r_id;
    w_onehot_nxt = r_onehot;
    w_ptr_nxt    = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt  = S_GRANT;
          w_id_nxt     = w_win;
          w_onehot_nxt = WIDTH'(1) << w_win;
        end
      end
      S_GRANT: begin
        if (gnt_ready) begin
          w_state_nxt  = S_IDLE;
          w_onehot_nxt = '0;
          if (MODE == 1) begin
            w_ptr_nxt = (r_id == ID_W'(WIDTH - 1)) ? '0 : r_id + ID_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_id     <= '0;
      r_onehot <= '0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_id     <= w_id_nxt;
      r_onehot <= w_onehot_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  assign gnt_valid  = (r_state == S_GRANT);
  assign gnt_id     = r_id;
  assign gnt_onehot = r_onehot;

endmodule
